// File: rtl/bus_pkg.sv
// Shared bus definitions: frame start marker, master FSM states and the
// control frame length calculation used by both master and slave.
package bus_pkg;

    localparam logic [2:0] START = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        WAIT_RDY,
        WR_LOAD,
        WR_SHIFT,
        RD_SHIFT,
        DONE
    } state_t;

    // Frame layout: start marker | id | rw | burst | addr
    function automatic int ctrl_len(input int id_width, input int addr_width);
        return 3 + id_width + 2 + addr_width;
    endfunction

endpackage

// File: rtl/bit_shifter.sv
// Parallel-in / serial-out shifter, MSB first. Zeros are shifted in, so the
// output returns to 0 once a full word has been sent.
module bit_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] r_data;

    // Load has priority over shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = r_data[WIDTH-1];

endmodule

// File: rtl/master_port.sv
// Serial bus master: sends a control frame, waits for the slave, then
// streams write words out on wD or assembles read words from rD.
module master_port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_DEPTH = 2000,
    parameter int SLAVES     = 3,
    parameter int S_ID_WIDTH = $clog2(SLAVES + 1),
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_start,
    input  logic [S_ID_WIDTH-1:0]         cmd_id,
    input  logic                          cmd_rw,
    input  logic                          cmd_burst,
    input  logic [$clog2(ADDR_DEPTH)-1:0] cmd_addr,
    input  logic [$clog2(MAX_BURST+1)-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic                          wdata_req,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          rdata_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          control,
    output logic                          wD,
    output logic                          valid,
    output logic                          last,
    input  logic                          rD,
    input  logic                          ready
);

    localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH);
    localparam int LEN_W      = $clog2(MAX_BURST + 1);
    localparam int CTRL_LEN   = ctrl_len(S_ID_WIDTH, ADDR_WIDTH);
    localparam int CNT_MAX    = (CTRL_LEN > DATA_WIDTH) ? CTRL_LEN : DATA_WIDTH;
    localparam int CNT_W      = $clog2(CNT_MAX);
    localparam int TO_W       = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BURST);

    state_t                  r_state;
    logic                    r_rw;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_word_cnt;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [TO_W-1:0]         r_to_cnt;
    logic [DATA_WIDTH-2:0]   r_rx;

    logic [LEN_W-1:0]        w_len;
    logic                    w_final;
    logic                    w_next_final;
    logic [CTRL_LEN-1:0]     w_frame;

    // Effective word count: single word unless bursting, zero means one,
    // oversize requests are clamped
    always_comb begin
        w_len = cmd_len;
        if (!cmd_burst || cmd_len == '0) begin
            w_len = LEN_ONE;
        end else if (cmd_len > LEN_MAX) begin
            w_len = LEN_MAX;
        end
    end

    assign w_final      = (r_word_cnt == r_len - LEN_ONE);
    assign w_next_final = (r_word_cnt + LEN_ONE == r_len - LEN_ONE);
    assign w_frame      = {START, cmd_id, cmd_rw, cmd_burst, cmd_addr};

    // Control frame goes out of its own shifter; it empties itself during CTRL
    bit_shifter #(.WIDTH(CTRL_LEN)) u_ctrl_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (r_state == IDLE && cmd_start),
        .shift (r_state == CTRL),
        .din   (w_frame),
        .dout  (control)
    );

    // Write word shifter, loaded in the wdata_req cycle
    bit_shifter #(.WIDTH(DATA_WIDTH)) u_tx_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (r_state == WR_LOAD),
        .shift (r_state == WR_SHIFT),
        .din   (wdata),
        .dout  (wD)
    );

    // Transaction FSM with registered strobes and qualifiers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rw        <= 1'b0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_rx        <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wdata_req   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            valid       <= 1'b0;
            last        <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            wdata_req   <= 1'b0;
            rdata_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_start) begin
                        r_rw       <= cmd_rw;
                        r_len      <= w_len;
                        r_word_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_to_cnt   <= '0;
                        busy       <= 1'b1;
                        r_state    <= CTRL;
                    end
                end
                CTRL: begin
                    if (r_bit_cnt == CTRL_LAST) begin
                        r_bit_cnt <= '0;
                        r_state   <= WAIT_RDY;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (ready) begin
                        r_to_cnt <= '0;
                        if (r_rw) begin
                            wdata_req <= 1'b1;
                            r_state   <= WR_LOAD;
                        end else begin
                            last    <= w_final;
                            r_state <= RD_SHIFT;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        valid    <= 1'b0;
                        last     <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                WR_LOAD: begin
                    valid   <= 1'b1;
                    last    <= w_final;
                    r_state <= WR_SHIFT;
                end
                WR_SHIFT: begin
                    if (r_bit_cnt == DATA_LAST) begin
                        r_bit_cnt <= '0;
                        valid     <= 1'b0;
                        last      <= 1'b0;
                        if (w_final) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + LEN_ONE;
                            wdata_req  <= 1'b1;
                            r_state    <= WR_LOAD;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                RD_SHIFT: begin
                    if (ready) begin
                        r_to_cnt <= '0;
                        r_rx     <= {r_rx[DATA_WIDTH-3:0], rD};
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt   <= '0;
                            rdata       <= {r_rx, rD};
                            rdata_valid <= 1'b1;
                            if (w_final) begin
                                last    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_word_cnt <= r_word_cnt + LEN_ONE;
                                last       <= w_next_final;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        valid     <= 1'b0;
                        last      <= 1'b0;
                        r_to_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: the bench plays the slave and checks
// frames, serial data, strobes, timeouts and reset abort.
module tb_master_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic [1:0]  cmd_id = '0;
    logic        cmd_rw = 1'b0;
    logic        cmd_burst = 1'b0;
    logic [10:0] cmd_addr = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] wdata = '0;
    logic        rD = 1'b0;
    logic        ready = 1'b0;
    logic        wdata_req, rdata_valid, busy, done, err, control, wD, valid, last;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_pass = 0;

    // Results gathered by run_txn
    logic [17:0] ctrl_bits;
    int          ctrl_extra, n_req, wd_nwords, n_gaps, gap_sum, n_done, n_err;
    int          err_cyc, end_cyc, n_rdv;
    logic [31:0] wr_words [16];
    logic [31:0] wr_out   [16];
    logic [31:0] rd_words [16];
    logic [31:0] rd_out   [16];
    int          last_cnt [16];
    int          rd_last_cnt [16];
    logic        busy_at_err, pre_valid;
    logic [1:0]  vl_at_err;
    logic [8:0]  snap;
    logic [31:0] snap_rdata;
    bit          timed_out;

    master_port dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_id      (cmd_id),
        .cmd_rw      (cmd_rw),
        .cmd_burst   (cmd_burst),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata       (wdata),
        .wdata_req   (wdata_req),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .control     (control),
        .wD          (wD),
        .valid       (valid),
        .last        (last),
        .rD          (rD),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] frame(input logic [1:0] id, input logic rw,
                                          input logic b, input logic [10:0] a);
        return {3'b111, id, rw, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] id, input logic rw, input logic b,
                             input logic [10:0] a, input logic [4:0] len);
        ready     = 1'b0;
        cmd_id    = id;
        cmd_rw    = rw;
        cmd_burst = b;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Plays the slave and records outputs, one sample per cycle, until done/err
    task automatic run_txn(input int rdy_from, input int stall_at, input int stall_len,
                           input int poke_cyc, input int rst_at, input int limit);
        int          ptr = 0;
        int          stall_rem = stall_len;
        int          bits = 0;
        int          gap = 0;
        bit          rd_started = 0;
        bit          prev_valid = 0;
        bit          seen_valid = 0;
        bit          fin = 0;
        bit          rdy;
        logic [31:0] acc = '0;
        ctrl_bits = '0; ctrl_extra = 0; n_req = 0; wd_nwords = 0; n_gaps = 0; gap_sum = 0;
        n_done = 0; n_err = 0; err_cyc = -1; end_cyc = -1; n_rdv = 0; timed_out = 0;
        busy_at_err = 1'bx; vl_at_err = 2'bxx; pre_valid = 1'bx;
        for (int i = 0; i < 16; i++) begin
            last_cnt[i] = 0;
            rd_last_cnt[i] = 0;
            wr_out[i] = '0;
            rd_out[i] = '0;
        end
        for (int cyc = 0; cyc < limit && !fin; cyc++) begin
            if (cyc < 18) ctrl_bits = {ctrl_bits[16:0], control};
            else if (control !== 1'b0) ctrl_extra++;
            if (wdata_req === 1'b1) begin
                wdata = wr_words[n_req % 16];
                n_req++;
            end
            if (valid === 1'b1) begin
                if (!prev_valid && seen_valid) begin
                    n_gaps++;
                    gap_sum += gap;
                end
                acc = {acc[30:0], wD};
                if (last === 1'b1) last_cnt[wd_nwords % 16]++;
                bits++;
                if (bits == 32) begin
                    wr_out[wd_nwords % 16] = acc;
                    wd_nwords++;
                    bits = 0;
                end
                seen_valid = 1;
                gap = 0;
            end else begin
                gap++;
            end
            prev_valid = (valid === 1'b1);
            if (rdata_valid === 1'b1) begin
                rd_out[n_rdv % 16] = rdata;
                n_rdv++;
            end
            if (done === 1'b1) n_done++;
            if (err === 1'b1) begin
                n_err++;
                err_cyc = cyc;
                busy_at_err = busy;
                vl_at_err = {valid, last};
            end
            if (done === 1'b1 || err === 1'b1) begin
                fin = 1;
                end_cyc = cyc;
            end else if (cyc == rst_at) begin
                pre_valid = valid;
                rst = 1'b1;
                #1;
                snap = {control, wD, valid, last, busy, done, err, wdata_req, rdata_valid};
                snap_rdata = rdata;
                fin = 1;
                end_cyc = cyc;
            end else begin
                cmd_start = (cyc == poke_cyc);
                rdy = (cyc >= rdy_from);
                if (rdy && rd_started && ptr == stall_at && stall_rem > 0) begin
                    rdy = 0;
                    stall_rem--;
                end
                rD = 1'b0;
                if (rdy && cyc >= 18) begin
                    if (rd_started) begin
                        if (ptr < 512) begin
                            rD = rd_words[ptr / 32][31 - (ptr % 32)];
                            if (ptr / 32 < 16) rd_last_cnt[ptr / 32] += int'(last === 1'b1);
                        end
                        ptr++;
                    end else begin
                        rd_started = 1;
                    end
                end
                ready = rdy;
                tick();
            end
        end
        cmd_start = 1'b0;
        ready = 1'b0;
        if (!fin) timed_out = 1;
        n_checks++;
        if (timed_out) $display("FAIL txn_bound: no done/err within %0d cycles, required completion", limit);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({control, wD, valid, last, busy, done, err, wdata_req, rdata_valid} !== 9'b0)
            $display("FAIL reset_outputs: got %b required 000000000",
                     {control, wD, valid, last, busy, done, err, wdata_req, rdata_valid});
        else n_pass++;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 00000000", rdata);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        wr_words[0] = 32'hDEADBEEF;
        drive_cmd(2'd1, 1'b1, 1'b0, 11'd5, 5'd0);
        run_txn(18, -1, 0, 5, -1, 200);
        n_checks++;
        if (ctrl_bits !== 18'b111_01_1_0_00000000101)
            $display("FAIL wr1_frame: got %b required %b", ctrl_bits, 18'b111_01_1_0_00000000101);
        else n_pass++;
        n_checks++;
        if (ctrl_extra !== 0) $display("FAIL wr1_ctrl_idle: got %0d nonzero control cycles required 0", ctrl_extra);
        else n_pass++;
        n_checks++;
        if (wd_nwords !== 1 || wr_out[0] !== 32'hDEADBEEF)
            $display("FAIL wr1_data: got %0d words first %h required 1 word DEADBEEF", wd_nwords, wr_out[0]);
        else n_pass++;
        n_checks++;
        if (last_cnt[0] !== 32) $display("FAIL wr1_last: got %0d last cycles required 32", last_cnt[0]);
        else n_pass++;
        n_checks++;
        if (n_req !== 1) $display("FAIL wr1_req: got %0d wdata_req required 1", n_req);
        else n_pass++;
        n_checks++;
        if (n_done !== 1 || n_err !== 0 || end_cyc !== 52)
            $display("FAIL wr1_done: got done=%0d err=%0d at cycle %0d required 1/0 at 52", n_done, n_err, end_cyc);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL wr1_idle: got busy=%b done=%b required 0/0", busy, done);
        else n_pass++;
    endtask

    task automatic test_single_read();
        rd_words[0] = 32'hA5A5_0F0F;
        drive_cmd(2'd2, 1'b0, 1'b0, 11'd7, 5'd0);
        run_txn(20, -1, 0, -1, -1, 200);
        n_checks++;
        if (ctrl_bits !== frame(2'd2, 1'b0, 1'b0, 11'd7))
            $display("FAIL rd1_frame: got %b required %b", ctrl_bits, frame(2'd2, 1'b0, 1'b0, 11'd7));
        else n_pass++;
        n_checks++;
        if (n_rdv !== 1 || rd_out[0] !== 32'hA5A50F0F)
            $display("FAIL rd1_data: got %0d words first %h required 1 word A5A50F0F", n_rdv, rd_out[0]);
        else n_pass++;
        n_checks++;
        if (rd_last_cnt[0] !== 32 || n_req !== 0)
            $display("FAIL rd1_last_req: got last=%0d req=%0d required 32/0", rd_last_cnt[0], n_req);
        else n_pass++;
        n_checks++;
        if (n_done !== 1 || n_err !== 0 || end_cyc !== 53)
            $display("FAIL rd1_done: got done=%0d err=%0d at cycle %0d required 1/0 at 53", n_done, n_err, end_cyc);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (rdata !== 32'hA5A50F0F) $display("FAIL rd1_hold: got %h required A5A50F0F", rdata);
        else n_pass++;
    endtask

    task automatic test_burst_write();
        wr_words[0] = 32'd1;
        wr_words[1] = 32'd2;
        wr_words[2] = 32'd3;
        drive_cmd(2'd0, 1'b1, 1'b1, 11'h123, 5'd3);
        run_txn(18, -1, 0, -1, -1, 300);
        n_checks++;
        if (n_req !== 3) $display("FAIL bw_req: got %0d wdata_req required 3", n_req);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_out[i] !== 32'(i + 1) || last_cnt[i] !== (i == 2 ? 32 : 0))
                $display("FAIL bw_word%0d: got %h last=%0d required %h last=%0d",
                         i, wr_out[i], last_cnt[i], 32'(i + 1), (i == 2 ? 32 : 0));
            else n_pass++;
        end
        n_checks++;
        if (n_gaps !== 2 || gap_sum !== 2)
            $display("FAIL bw_gap: got %0d gaps of %0d cycles required 2 gaps of 2", n_gaps, gap_sum);
        else n_pass++;
        n_checks++;
        if (n_done !== 1 || end_cyc !== 118)
            $display("FAIL bw_done: got done=%0d at cycle %0d required 1 at 118", n_done, end_cyc);
        else n_pass++;
        tick();
    endtask

    task automatic test_burst_read();
        rd_words[0] = 32'h0123_4567;
        rd_words[1] = 32'h89AB_CDEF;
        rd_words[2] = 32'hFFFF_0000;
        rd_words[3] = 32'h5A5A_C3C3;
        drive_cmd(2'd3, 1'b0, 1'b1, 11'h7FF, 5'd4);
        run_txn(18, 48, 5, -1, -1, 400);
        n_checks++;
        if (n_rdv !== 4) $display("FAIL br_count: got %0d rdata_valid required 4", n_rdv);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_out[i] !== rd_words[i] || rd_last_cnt[i] !== (i == 3 ? 32 : 0))
                $display("FAIL br_word%0d: got %h last=%0d required %h last=%0d",
                         i, rd_out[i], rd_last_cnt[i], rd_words[i], (i == 3 ? 32 : 0));
            else n_pass++;
        end
        n_checks++;
        if (n_err !== 0 || n_done !== 1 || end_cyc !== 152)
            $display("FAIL br_done: got err=%0d done=%0d at cycle %0d required 0/1 at 152", n_err, n_done, end_cyc);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        drive_cmd(2'd1, 1'b0, 1'b0, 11'd9, 5'd0);
        run_txn(100000, -1, 0, -1, -1, 400);
        n_checks++;
        if (n_err !== 1 || err_cyc !== 273)
            $display("FAIL to_err: got %0d err pulses at cycle %0d required 1 at 273", n_err, err_cyc);
        else n_pass++;
        n_checks++;
        if (busy_at_err !== 1'b0 || vl_at_err !== 2'b00 || n_done !== 0)
            $display("FAIL to_state: got busy=%b valid/last=%b done=%0d required 0/00/0", busy_at_err, vl_at_err, n_done);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) $display("FAIL to_pulse: got err=%b busy=%b required 0/0", err, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wr_words[0] = 32'h1234_5678;
        drive_cmd(2'd1, 1'b1, 1'b0, 11'd5, 5'd0);
        run_txn(18, -1, 0, -1, 30, 200);
        n_checks++;
        if (pre_valid !== 1'b1) $display("FAIL rm_in_shift: got valid=%b before reset required 1", pre_valid);
        else n_pass++;
        n_checks++;
        if (snap !== 9'b0 || snap_rdata !== 32'h0)
            $display("FAIL rm_outputs: got %b rdata %h required 000000000 rdata 00000000", snap, snap_rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0) $display("FAIL rm_nostrobe: got done=%b err=%b required 0/0", done, err);
        else n_pass++;
        rst = 1'b0;
        tick();
        wr_words[0] = 32'hCAFE_F00D;
        drive_cmd(2'd2, 1'b1, 1'b0, 11'd3, 5'd0);
        run_txn(18, -1, 0, -1, -1, 200);
        n_checks++;
        if (wr_out[0] !== 32'hCAFEF00D || n_done !== 1 || ctrl_bits !== frame(2'd2, 1'b1, 1'b0, 11'd3))
            $display("FAIL rm_next: got %h done=%0d frame %b required CAFEF00D 1 %b",
                     wr_out[0], n_done, ctrl_bits, frame(2'd2, 1'b1, 1'b0, 11'd3));
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        wr_words[0] = 32'h0F0F_F0F0;
        drive_cmd(2'd1, 1'b1, 1'b1, 11'd2, 5'd0);
        run_txn(18, -1, 0, -1, -1, 200);
        n_checks++;
        if (wd_nwords !== 1 || wr_out[0] !== 32'h0F0FF0F0 || last_cnt[0] !== 32)
            $display("FAIL b2b_len0: got %0d words %h last=%0d required 1 word 0F0FF0F0 last=32",
                     wd_nwords, wr_out[0], last_cnt[0]);
        else n_pass++;
        tick();
        for (int i = 0; i < 16; i++) rd_words[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        drive_cmd(2'd2, 1'b0, 1'b1, 11'd4, 5'd20);
        run_txn(18, -1, 0, -1, -1, 800);
        n_checks++;
        if (ctrl_bits !== frame(2'd2, 1'b0, 1'b1, 11'd4))
            $display("FAIL b2b_frame: got %b required %b", ctrl_bits, frame(2'd2, 1'b0, 1'b1, 11'd4));
        else n_pass++;
        n_checks++;
        if (n_rdv !== 16 || rd_last_cnt[15] !== 32 || rd_last_cnt[14] !== 0 || n_done !== 1)
            $display("FAIL b2b_clamp: got %0d words last15=%0d last14=%0d done=%0d required 16/32/0/1",
                     n_rdv, rd_last_cnt[15], rd_last_cnt[14], n_done);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rd_out[i] !== 32'h1000_0000 + 32'(i) * 32'h0101)
                $display("FAIL b2b_word%0d: got %h required %h", i, rd_out[i], 32'h1000_0000 + 32'(i) * 32'h0101);
            else n_pass++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_write();
        test_burst_read();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
